// File: rtl/direct_mapped_cache_if.sv
// CPU-side and memory-side signal bundle for the direct-mapped cache.
// The slave modport is the cache's view; master is the view of the CPU/memory environment.
interface direct_mapped_cache_if #(
  parameter int unsigned DATA_W = 13,
  parameter int unsigned ADDR_W = 10
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_done;
  logic              cpu_busy;
  logic              cpu_hit;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
    output cpu_rdata, cpu_done, cpu_busy, cpu_hit, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
    input  cpu_rdata, cpu_done, cpu_busy, cpu_hit, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/direct_mapped_cache.sv
// Direct-mapped, write-through, no-write-allocate cache with a multi-word line refill.
// All outputs are registered; the data and tag arrays carry no reset.
module direct_mapped_cache #(
  parameter int unsigned DATA_W   = 13,
  parameter int unsigned INDEX_W  = 3,
  parameter int unsigned OFFSET_W = 2,
  parameter int unsigned ADDR_W   = 10
) (
  input logic                  clk,
  input logic                  reset,
  direct_mapped_cache_if.slave bus
);

  localparam int unsigned TAG_W = ADDR_W - INDEX_W - OFFSET_W;
  localparam int unsigned LINES = 1 << INDEX_W;
  localparam int unsigned WORDS = 1 << OFFSET_W;

  typedef enum logic [1:0] {IDLE, REFILL, WRITE_MEM, RESPOND} state_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0] data_mem [LINES][WORDS];
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [LINES-1:0]  valid_q, valid_d;

  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                hit_q, hit_d;
  logic [OFFSET_W-1:0] word_q, word_d;

  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              hit_out_q, hit_out_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  logic                arr_we;
  logic [INDEX_W-1:0]  arr_idx;
  logic [OFFSET_W-1:0] arr_off;
  logic [DATA_W-1:0]   arr_wdata;
  logic                tag_we;

  logic [TAG_W-1:0]    req_tag, lat_tag;
  logic [INDEX_W-1:0]  req_idx, lat_idx;
  logic [OFFSET_W-1:0] req_off, lat_off;
  logic                lookup_hit;

  assign req_off = bus.cpu_addr[OFFSET_W-1:0];
  assign req_idx = bus.cpu_addr[OFFSET_W +: INDEX_W];
  assign req_tag = bus.cpu_addr[ADDR_W-1 -: TAG_W];
  assign lat_off = addr_q[OFFSET_W-1:0];
  assign lat_idx = addr_q[OFFSET_W +: INDEX_W];
  assign lat_tag = addr_q[ADDR_W-1 -: TAG_W];

  assign lookup_hit = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);

  // Next-state, next-output and array write-port decode
  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    addr_d      = addr_q;
    hit_d       = hit_q;
    word_d      = word_q;
    rdata_d     = rdata_q;
    done_d      = 1'b0;
    hit_out_d   = hit_out_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    arr_we      = 1'b0;
    arr_idx     = lat_idx;
    arr_off     = lat_off;
    arr_wdata   = bus.mem_rdata;
    tag_we      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.cpu_req) begin
          addr_d = bus.cpu_addr;
          hit_d  = lookup_hit;
          if (bus.cpu_we) begin
            state_d     = WRITE_MEM;
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b1;
            mem_addr_d  = bus.cpu_addr;
            mem_wdata_d = bus.cpu_wdata;
            // Write-through: update the cached copy only when the line is present
            if (lookup_hit) begin
              arr_we    = 1'b1;
              arr_idx   = req_idx;
              arr_off   = req_off;
              arr_wdata = bus.cpu_wdata;
            end
          end else if (lookup_hit) begin
            state_d = RESPOND;
          end else begin
            state_d          = REFILL;
            word_d           = '0;
            valid_d[req_idx] = 1'b0;
            mem_req_d        = 1'b1;
            mem_we_d         = 1'b0;
            mem_addr_d       = {req_tag, req_idx, OFFSET_W'(0)};
          end
        end
      end

      REFILL: begin
        if (mem_req_q) begin
          if (bus.mem_ack) begin
            arr_we    = 1'b1;
            arr_off   = word_q;
            mem_req_d = 1'b0;
            if (word_q == OFFSET_W'(WORDS - 1)) begin
              tag_we           = 1'b1;
              valid_d[lat_idx] = 1'b1;
              state_d          = RESPOND;
            end else begin
              word_d = word_q + OFFSET_W'(1);
            end
          end
        end else begin
          // One idle cycle between words before the next fetch
          mem_req_d  = 1'b1;
          mem_addr_d = {lat_tag, lat_idx, word_q};
        end
      end

      WRITE_MEM: begin
        if (bus.mem_ack) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          state_d   = RESPOND;
        end
      end

      RESPOND: begin
        done_d    = 1'b1;
        hit_out_d = hit_q;
        rdata_d   = data_mem[lat_idx][lat_off];
        state_d   = IDLE;
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // Control state and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      addr_q      <= '0;
      hit_q       <= 1'b0;
      word_q      <= '0;
      rdata_q     <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      hit_out_q   <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      addr_q      <= addr_d;
      hit_q       <= hit_d;
      word_q      <= word_d;
      rdata_q     <= rdata_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      hit_out_q   <= hit_out_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Data and tag storage
  always_ff @(posedge clk) begin
    if (arr_we && !reset) begin
      data_mem[arr_idx][arr_off] <= arr_wdata;
    end
    if (tag_we && !reset) begin
      tag_mem[lat_idx] <= lat_tag;
    end
  end

  assign bus.cpu_rdata = rdata_q;
  assign bus.cpu_done  = done_q;
  assign bus.cpu_busy  = busy_q;
  assign bus.cpu_hit   = hit_out_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_direct_mapped_cache.sv
// Self-checking bench for direct_mapped_cache: table-driven CPU accesses against a
// memory responder, with scoreboard queues for expected memory traffic and CPU responses.
module tb_direct_mapped_cache;

  localparam int unsigned DATA_W = 13;
  localparam int unsigned ADDR_W = 10;
  localparam int NVEC = 16;

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              hit;
    int                lat;
  } vec_t;

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } memop_t;

  typedef struct {
    logic              we;
    logic [DATA_W-1:0] rdata;
    logic              hit;
    int                lat;
  } cpuexp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  direct_mapped_cache_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  direct_mapped_cache #(
    .DATA_W(DATA_W), .INDEX_W(3), .OFFSET_W(2), .ADDR_W(ADDR_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  memop_t            mem_q[$];
  cpuexp_t           cpu_q[$];
  logic [DATA_W-1:0] mem_model [1024];
  vec_t              vecs [NVEC];
  cpuexp_t           mon_e;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int req_cyc = 0;
  int done_cnt = 0;
  int ack_total = 0;
  int stall_at = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // CPU response scoreboard
  always @(negedge clk) begin
    if (bus.cpu_done) begin
      done_cnt++;
      if (cpu_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        mon_e = cpu_q.pop_front();
        if (!mon_e.we) chk("cpu_rdata", 32'(bus.cpu_rdata), 32'(mon_e.rdata));
        chk("cpu_hit", 32'(bus.cpu_hit), 32'(mon_e.hit));
        chk("busy_with_done", 32'(bus.cpu_busy), 32'd0);
        chk("memops_left", 32'(mem_q.size()), 32'd0);
        if (mon_e.lat != 0) chk("hit_latency", 32'(cyc - req_cyc + 1), 32'(mon_e.lat));
      end
    end
  end

  task automatic serve();
    memop_t op;
    if (mem_q.size() == 0) begin
      chk("unexpected_mem_req", 32'(bus.mem_addr), 32'h7fff_ffff);
      bus.mem_rdata = '0;
    end else begin
      op = mem_q.pop_front();
      chk("mem_we", 32'(bus.mem_we), 32'(op.we));
      chk("mem_addr", 32'(bus.mem_addr), 32'(op.addr));
      if (op.we) begin
        chk("mem_wdata", 32'(bus.mem_wdata), 32'(op.wdata));
        mem_model[bus.mem_addr] = bus.mem_wdata;
      end else begin
        bus.mem_rdata = mem_model[bus.mem_addr];
      end
    end
  endtask

  // Main-memory responder with random ack delay; a stray ack is driven during reset
  initial begin
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (reset && bus.mem_req) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 13'h1FFF;
        @(negedge clk);
        bus.mem_ack = 1'b0;
      end else if (!reset && bus.mem_req && (stall_at < 0 || ack_total < stall_at)) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        serve();
        bus.mem_ack = 1'b1;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        ack_total++;
        chk("mem_req_gap", 32'(bus.mem_req), 32'd0);
      end
    end
  end

  task automatic push_expect(input vec_t v);
    logic [ADDR_W-1:0] base;
    memop_t op;
    cpuexp_t e;
    base = {v.addr[ADDR_W-1:2], 2'b00};
    if (v.we) begin
      op.we = 1'b1; op.addr = v.addr; op.wdata = v.wdata;
      mem_q.push_back(op);
    end else if (!v.hit) begin
      for (int w = 0; w < 4; w++) begin
        op.we = 1'b0; op.addr = base + ADDR_W'(w); op.wdata = '0;
        mem_q.push_back(op);
      end
    end
    e.we = v.we; e.rdata = v.rdata; e.hit = v.hit; e.lat = v.lat;
    cpu_q.push_back(e);
  endtask

  task automatic issue(input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd);
    @(negedge clk);
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = we;
    bus.cpu_addr  = a;
    bus.cpu_wdata = wd;
    @(negedge clk);
    req_cyc     = cyc;
    bus.cpu_req = 1'b0;
  endtask

  task automatic wait_done(input int start, input string name);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done_cnt != start) return;
    end
    chk(name, 32'd0, 32'd1);
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int start;
    start = done_cnt;
    push_expect(v);
    issue(v.we, v.addr, v.wdata);
    wait_done(start, name);
  endtask

  initial begin
    vec_t v;
    int   found;
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    for (int i = 0; i < 1024; i++) mem_model[i] = 13'(i + 'h100);

    //             we    addr     wdata     rdata     hit  lat
    vecs[0]  = '{1'b0, 10'h005, 13'h000,  13'h105,  1'b0, 0};
    vecs[1]  = '{1'b0, 10'h006, 13'h000,  13'h106,  1'b1, 2};
    vecs[2]  = '{1'b1, 10'h006, 13'h0AA,  13'h000,  1'b1, 0};
    vecs[3]  = '{1'b0, 10'h006, 13'h000,  13'h0AA,  1'b1, 2};
    vecs[4]  = '{1'b1, 10'h3F0, 13'h055,  13'h000,  1'b0, 0};
    vecs[5]  = '{1'b0, 10'h3F0, 13'h000,  13'h055,  1'b0, 0};
    vecs[6]  = '{1'b0, 10'h3F3, 13'h000,  13'h4F3,  1'b1, 2};
    vecs[7]  = '{1'b0, 10'h025, 13'h000,  13'h125,  1'b0, 0};
    vecs[8]  = '{1'b0, 10'h005, 13'h000,  13'h105,  1'b0, 0};
    vecs[9]  = '{1'b0, 10'h025, 13'h000,  13'h125,  1'b0, 0};
    vecs[10] = '{1'b0, 10'h004, 13'h000,  13'h104,  1'b0, 0};
    vecs[11] = '{1'b0, 10'h006, 13'h000,  13'h0AA,  1'b1, 2};
    vecs[12] = '{1'b1, 10'h025, 13'h1234, 13'h000,  1'b0, 0};
    vecs[13] = '{1'b0, 10'h025, 13'h000,  13'h1234, 1'b0, 0};
    vecs[14] = '{1'b1, 10'h027, 13'h0F0,  13'h000,  1'b1, 0};
    vecs[15] = '{1'b0, 10'h027, 13'h000,  13'h0F0,  1'b1, 2};

    repeat (3) @(negedge clk);
    chk("rst_cpu_done",  32'(bus.cpu_done),  32'd0);
    chk("rst_cpu_busy",  32'(bus.cpu_busy),  32'd0);
    chk("rst_cpu_hit",   32'(bus.cpu_hit),   32'd0);
    chk("rst_cpu_rdata", 32'(bus.cpu_rdata), 32'd0);
    chk("rst_mem_req",   32'(bus.mem_req),   32'd0);
    chk("rst_mem_we",    32'(bus.mem_we),    32'd0);
    chk("rst_mem_addr",  32'(bus.mem_addr),  32'd0);
    chk("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < NVEC; i++) run_vec(vecs[i], $sformatf("done_timeout_vec%0d", i));

    // Reset while the third refill word is outstanding, then refetch the full line
    mem_q.push_back('{1'b0, 10'h048, 13'h000});
    mem_q.push_back('{1'b0, 10'h049, 13'h000});
    stall_at = ack_total + 2;
    issue(1'b0, 10'h04A, 13'h000);
    found = 0;
    for (int i = 0; i < 200 && found == 0; i++) begin
      @(negedge clk);
      if (bus.mem_req && ack_total == stall_at) found = 1;
    end
    chk("third_req_seen", 32'(found), 32'd1);
    chk("third_req_addr", 32'(bus.mem_addr), 32'h04A);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    stall_at = -1;
    @(negedge clk);
    chk("abort_mem_req",  32'(bus.mem_req),  32'd0);
    chk("abort_cpu_busy", 32'(bus.cpu_busy), 32'd0);
    chk("abort_cpu_done", 32'(bus.cpu_done), 32'd0);
    chk("abort_mem_addr", 32'(bus.mem_addr), 32'd0);
    repeat (3) @(negedge clk);
    chk("abort_idle_req", 32'(bus.mem_req), 32'd0);
    v = '{1'b0, 10'h04A, 13'h000, 13'h14A, 1'b0, 0};
    run_vec(v, "done_timeout_reread");
    v = '{1'b0, 10'h04B, 13'h000, 13'h14B, 1'b1, 2};
    run_vec(v, "done_timeout_after_reread");

    repeat (5) @(negedge clk);
    chk("cpu_q_empty", 32'(cpu_q.size()), 32'd0);
    chk("mem_q_empty", 32'(mem_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/direct_mapped_cache.md
DIRECT_MAPPED_CACHE -- requirements
Module: direct_mapped_cache

Interface
REQ-001 The block SHALL expose parameter DATA_W, default 13, meaning the bit width of one data word.
REQ-002 The block SHALL expose parameter INDEX_W, default 3, meaning the index bits; the cache SHALL have 2^INDEX_W lines.
REQ-003 The block SHALL expose parameter OFFSET_W, default 2, meaning the word-offset bits; each line SHALL hold 2^OFFSET_W words.
REQ-004 The block SHALL expose parameter ADDR_W, default 10, meaning the word-address width; TAG_W SHALL equal ADDR_W-INDEX_W-OFFSET_W and SHALL be at least 1.
REQ-005 The block SHALL have port clk, input, 1 bit, the single clock; all state SHALL update on the rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit, the synchronous active-high reset.
REQ-007 The block SHALL have port cpu_req, input, 1 bit, a request strobe that is sampled only while cpu_busy=0.
REQ-008 The block SHALL have port cpu_we, input, 1 bit, where 1 means write and 0 means read.
REQ-009 The block SHALL have port cpu_addr, input, ADDR_W bits, a word address split as {tag, index, offset}.
REQ-010 The block SHALL have port cpu_wdata, input, DATA_W bits, the write data.
REQ-011 The block SHALL have port cpu_rdata, output, DATA_W bits, the read data, which is valid while cpu_done=1.
REQ-012 The block SHALL have port cpu_done, output, 1 bit, a one-cycle completion pulse.
REQ-013 The block SHALL have port cpu_busy, output, 1 bit, which is 1 whenever the FSM is not in IDLE.
REQ-014 The block SHALL have port cpu_hit, output, 1 bit, which is valid with cpu_done and is 1 if the access hit at lookup.
REQ-015 The block SHALL have port mem_req, output, 1 bit, the main-memory request, which is held until mem_ack.
REQ-016 The block SHALL have port mem_we, output, 1 bit, the main-memory write enable, which is stable while mem_req=1.
REQ-017 The block SHALL have port mem_addr, output, ADDR_W bits, the main-memory word address.
REQ-018 The block SHALL have port mem_wdata, output, DATA_W bits, the main-memory write data.
REQ-019 The block SHALL have port mem_rdata, input, DATA_W bits, the main-memory read data, which is valid with mem_ack.
REQ-020 The block SHALL have port mem_ack, input, 1 bit, a one-cycle acknowledge; mem_ack while mem_req=0 SHALL be ignored.

Function
REQ-021 The storage SHALL consist of a data array [lines][words], a tag array, and one valid bit per line.
REQ-022 The FSM states SHALL be IDLE, REFILL, WRITE_MEM and RESPOND.
REQ-023 In IDLE with cpu_req=1, the block SHALL latch addr, we and wdata, and SHALL evaluate hit = valid[index] && tag match.
REQ-024 A read hit SHALL go IDLE->RESPOND and SHALL pulse cpu_done with cpu_rdata=data[index][offset] and cpu_hit=1, giving a latency of 2 cycles from the req edge to the done cycle.
REQ-025 A read miss SHALL go to REFILL and SHALL fetch words 0..2^OFFSET_W-1 of the block in ascending order, one mem_req/mem_ack transaction each, with mem_we=0 and mem_addr={tag,index,word}.
REQ-026 During REFILL, each mem_ack SHALL write mem_rdata into data[index][word]; the last ack SHALL set tag and valid, and the FSM SHALL then go to RESPOND with cpu_hit=0 and the requested word.
REQ-027 A new mem_req SHALL be asserted no earlier than the cycle after the previous ack, so mem_req is low for at least 1 cycle between words.
REQ-028 A write SHALL use write-through, no-write-allocate: the FSM SHALL go to WRITE_MEM and drive mem_req=1, mem_we=1, mem_addr=latched addr and mem_wdata=latched wdata until mem_ack.
REQ-029 On a write hit, the cache word SHALL be updated in the lookup cycle; on a write miss, the cache SHALL be unchanged.
REQ-030 After the write ack the FSM SHALL go to RESPOND and pulse cpu_done with cpu_hit reflecting the lookup result; cpu_rdata is don't-care.
REQ-031 RESPOND SHALL last exactly 1 cycle and SHALL then return to IDLE; a cpu_req asserted in that cycle SHALL be ignored.
REQ-032 mem_ack SHALL have no bound on its delay, and the block SHALL wait indefinitely.

Reset
REQ-033 reset=1 SHALL force the IDLE state, clear all valid bits, and set cpu_done, cpu_busy, cpu_hit, mem_req and mem_we to 0 and cpu_rdata, mem_addr and mem_wdata to 0.
REQ-034 Reset during REFILL or WRITE_MEM SHALL abort the operation, leave the partially filled line invalid, and ignore any mem_ack in the reset cycle.
REQ-035 Data and tag arrays SHALL NOT require reset.

Verification
REQ-036 Reset, then read addr 0x005 with memory returning M[a]=a+0x100 -> 4 mem reads at 0x004..0x007, then cpu_done with rdata=0x105 and hit=0.
REQ-037 Read 0x006 after REQ-036 -> no mem_req, cpu_done 2 cycles after the req edge, rdata=0x106, hit=1.
REQ-038 Write 0x006=0x0AA (hit) -> one mem write at 0x006 with data 0x0AA, done with hit=1; a subsequent read of 0x006 returns 0x0AA with no mem_req.
REQ-039 Write 0x3F0 (miss), then read 0x3F0 -> the write causes no line fill; the read misses and refills 0x3F0..0x3F3.
REQ-040 Conflict: read 0x005, then read 0x025 (same index, different tag), then read 0x005 -> miss, miss, miss, with refills each time.
REQ-041 Assert reset while waiting for the 3rd refill ack -> IDLE with mem_req=0; a re-read of the same address performs a full 4-word refill.
